// File: rtl/rsio_pkg.sv
// Shared types, constants and parameter checks for the redstone output capture block.
// Timestamp fields exist only when RSIO_TIMESTAMP_EN is defined.
package rsio_pkg;

  localparam int RSIO_N_SIG_DFLT      = 16;
  localparam int RSIO_FIFO_DEPTH_DFLT = 8;
  localparam int RSIO_TS_W_DFLT       = 16;

  function automatic int rsio_idx_w(input int n_sig);
    return (n_sig < 2) ? 1 : $clog2(n_sig);
  endfunction

  // The FIFO pointers wrap naturally, so the depth has to be a power of two.
  function automatic bit rsio_params_legal(input int n_sig, input int depth, input int ts_w);
    return (n_sig >= 2) && (depth >= 2) && ((depth & (depth - 1)) == 0) && (ts_w >= 1);
  endfunction

  typedef enum logic {
    RSIO_IDLE = 1'b0,
    RSIO_SCAN = 1'b1
  } rsio_state_e;

  localparam int RSIO_IDX_W_DFLT = rsio_idx_w(RSIO_N_SIG_DFLT);

  // Event layout for the default net count, as seen by host-side tooling.
  typedef struct packed {
    logic [RSIO_IDX_W_DFLT-1:0] idx;
    logic                       val;
`ifdef RSIO_TIMESTAMP_EN
    logic [RSIO_TS_W_DFLT-1:0]  ts;
`endif
  } rsio_evt_t;

endpackage

// File: rtl/rsio_fifo.sv
// First-word-fall-through event FIFO with asynchronous active-high reset.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rsio_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = i_pop && !o_empty;
    do_push  = i_push && (!o_full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/redstone_output_capture.sv
// Samples the redstone output nets once per tick and streams each changed bit to the host.
// Define RSIO_TIMESTAMP_EN to tag every event with the tick count of its snapshot.
module redstone_output_capture
  import rsio_pkg::*;
#(
  parameter int  N_SIG      = RSIO_N_SIG_DFLT,
  parameter int  FIFO_DEPTH = RSIO_FIFO_DEPTH_DFLT,
  parameter int  TS_W       = RSIO_TS_W_DFLT,
  localparam int IDX_W      = rsio_idx_w(N_SIG)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic [N_SIG-1:0] i_sig,
  output logic             o_evt_valid,
  input  logic             i_evt_ready,
  output logic [IDX_W-1:0] o_evt_idx,
  output logic             o_evt_val,
`ifdef RSIO_TIMESTAMP_EN
  output logic [TS_W-1:0]  o_evt_ts,
`endif
  output logic             o_busy,
  output logic             o_overflow,
  output logic             o_tick_miss,
  input  logic             i_clr_flags
);

  if (!rsio_params_legal(N_SIG, FIFO_DEPTH, TS_W)) begin : g_bad_params
    $error("redstone_output_capture: illegal N_SIG / FIFO_DEPTH / TS_W");
  end

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             val;
`ifdef RSIO_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  rsio_state_e      state_q, state_d;
  logic [N_SIG-1:0] snap_q, snap_d;
  logic [N_SIG-1:0] prev_q, prev_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic             tick_miss_q, tick_miss_d;
`ifdef RSIO_TIMESTAMP_EN
  logic [TS_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [TS_W-1:0]  ts_snap_q, ts_snap_d;
`endif

  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  evt_t push_evt, head_evt;

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    overflow_d  = overflow_q;
    tick_miss_d = tick_miss_q;
`ifdef RSIO_TIMESTAMP_EN
    tick_cnt_d  = tick_cnt_q;
    ts_snap_d   = ts_snap_q;
`endif
    fifo_push   = 1'b0;
    push_evt    = '0;
    fifo_pop    = o_evt_valid && i_evt_ready;

    if (i_clr_flags) begin
      overflow_d  = 1'b0;
      tick_miss_d = 1'b0;
    end

    case (state_q)
      RSIO_IDLE: begin
        if (i_tick) begin
          snap_d  = i_sig;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RSIO_SCAN;
`ifdef RSIO_TIMESTAMP_EN
          ts_snap_d  = tick_cnt_q;
          tick_cnt_d = tick_cnt_q + 1'b1;
`endif
        end
      end
      RSIO_SCAN: begin
        if (i_tick) begin
          tick_miss_d = 1'b1;
        end
        // A dropped change leaves prev untouched so the next tick reports it again.
        if (snap_q[idx_q] != prev_q[idx_q]) begin
          if (!fifo_full || fifo_pop) begin
            fifo_push     = 1'b1;
            push_evt.idx  = idx_q;
            push_evt.val  = snap_q[idx_q];
`ifdef RSIO_TIMESTAMP_EN
            push_evt.ts   = ts_snap_q;
`endif
            prev_d[idx_q] = snap_q[idx_q];
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (idx_q == IDX_W'(N_SIG - 1)) begin
          state_d = RSIO_IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = RSIO_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= RSIO_IDLE;
      snap_q      <= '0;
      prev_q      <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      tick_miss_q <= 1'b0;
`ifdef RSIO_TIMESTAMP_EN
      tick_cnt_q  <= '0;
      ts_snap_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      tick_miss_q <= tick_miss_d;
`ifdef RSIO_TIMESTAMP_EN
      tick_cnt_q  <= tick_cnt_d;
      ts_snap_q   <= ts_snap_d;
`endif
    end
  end

  rsio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_wdata (push_evt),
    .i_pop   (fifo_pop),
    .o_rdata (head_evt),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_evt_valid = !fifo_empty;
  assign o_evt_idx   = o_evt_valid ? head_evt.idx : '0;
  assign o_evt_val   = o_evt_valid && head_evt.val;
`ifdef RSIO_TIMESTAMP_EN
  assign o_evt_ts    = o_evt_valid ? head_evt.ts : '0;
`endif
  assign o_busy      = busy_q;
  assign o_overflow  = overflow_q;
  assign o_tick_miss = tick_miss_q;

endmodule

// File: tb/tb_redstone_output_capture.sv
// Self-checking bench for redstone_output_capture: event-queue model plus directed scenarios.
// Works in both builds; timestamp checks appear only when RSIO_TIMESTAMP_EN is defined.
`timescale 1ns/1ps
module tb_redstone_output_capture;

  localparam int N_SIG = 16;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        ready;
  logic        clr;
  logic [15:0] sig;
  logic        evt_valid;
  logic [3:0]  evt_idx;
  logic        evt_val;
`ifdef RSIO_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif
  logic        busy;
  logic        ovf;
  logic        miss;

  int tests = 0;
  int fails = 0;
  int got[$];

  always #5 clk = ~clk;

  redstone_output_capture #(
    .N_SIG      (N_SIG),
    .FIFO_DEPTH (DEPTH),
    .TS_W       (TS_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick      (tick),
    .i_sig       (sig),
    .o_evt_valid (evt_valid),
    .i_evt_ready (ready),
    .o_evt_idx   (evt_idx),
    .o_evt_val   (evt_val),
`ifdef RSIO_TIMESTAMP_EN
    .o_evt_ts    (evt_ts),
`endif
    .o_busy      (busy),
    .o_overflow  (ovf),
    .o_tick_miss (miss),
    .i_clr_flags (clr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a queue of pending events, the last reported value of each net,
  // and the position of the scan in progress.
  typedef struct {
    int idx;
    bit val;
    int ts;
  } mevt_t;

  mevt_t mq[$];
  bit    m_prev[N_SIG];
  bit    m_snap[N_SIG];
  bit    m_scanning;
  int    m_pos;
  bit    m_ovf;
  bit    m_miss;
  int    m_tcnt;
  int    m_tsnap;

  always @(posedge clk or posedge rst) begin : model_step
    bit    pop;
    bit    ovf_set;
    bit    miss_set;
    int    pre;
    mevt_t e;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < N_SIG; i++) begin
        m_prev[i] = 1'b0;
        m_snap[i] = 1'b0;
      end
      m_scanning = 1'b0;
      m_pos      = 0;
      m_ovf      = 1'b0;
      m_miss     = 1'b0;
      m_tcnt     = 0;
      m_tsnap    = 0;
    end else begin
      pre      = mq.size();
      pop      = (pre > 0) && (ready === 1'b1);
      ovf_set  = 1'b0;
      miss_set = m_scanning && (tick === 1'b1);
      if (pop) void'(mq.pop_front());
      if (m_scanning) begin
        if (m_snap[m_pos] != m_prev[m_pos]) begin
          if (pre < DEPTH || pop) begin
            e.idx = m_pos;
            e.val = m_snap[m_pos];
            e.ts  = m_tsnap;
            mq.push_back(e);
            m_prev[m_pos] = m_snap[m_pos];
          end else begin
            ovf_set = 1'b1;
          end
        end
        m_pos++;
        if (m_pos == N_SIG) m_scanning = 1'b0;
      end else if (tick === 1'b1) begin
        for (int i = 0; i < N_SIG; i++) m_snap[i] = sig[i];
        m_tsnap    = m_tcnt;
        m_tcnt     = (m_tcnt + 1) % (1 << TS_W);
        m_scanning = 1'b1;
        m_pos      = 0;
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (clr === 1'b1) m_ovf = 1'b0;
      if (miss_set) m_miss = 1'b1;
      else if (clr === 1'b1) m_miss = 1'b0;
    end
  end

  // Compare the DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checkOutput("m_valid", 32'(evt_valid), 32'(mq.size() > 0));
      checkOutput("m_busy", 32'(busy), 32'(m_scanning));
      checkOutput("m_overflow", 32'(ovf), 32'(m_ovf));
      checkOutput("m_tick_miss", 32'(miss), 32'(m_miss));
      if (mq.size() > 0) begin
        checkOutput("m_idx", 32'(evt_idx), 32'(mq[0].idx));
        checkOutput("m_val", 32'(evt_val), 32'(mq[0].val));
`ifdef RSIO_TIMESTAMP_EN
        checkOutput("m_ts", 32'(evt_ts), 32'(mq[0].ts));
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one cycle of inputs; tick and clear are single-cycle pulses.
  task automatic applyStimulus(input logic [15:0] s, input logic t, input logic r, input logic c);
    sig   = s;
    tick  = t;
    ready = r;
    clr   = c;
    step(1);
    tick = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic resetDut();
    rst   = 1'b1;
    tick  = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    sig   = 16'h0000;
    step(2);
    checkOutput("rst_valid", 32'(evt_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_overflow", 32'(ovf), 0);
    checkOutput("rst_tick_miss", 32'(miss), 0);
    checkOutput("rst_idx", 32'(evt_idx), 0);
    checkOutput("rst_val", 32'(evt_val), 0);
    rst = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    checkOutput("idle_timeout", 32'(busy), 0);
  endtask

  // Record every accepted event index until the block is idle and the FIFO is drained.
  task automatic collectUntilQuiet();
    int n = 0;
    while ((busy === 1'b1 || evt_valid === 1'b1) && n < 200) begin
      if (evt_valid === 1'b1 && ready === 1'b1) got.push_back(int'(evt_idx));
      step(1);
      n++;
    end
    checkOutput("collect_timeout", 32'(busy | evt_valid), 0);
  endtask

  initial begin : watchdog
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int cnt;
    rst   = 1'b1;
    tick  = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    sig   = 16'h0000;

    // 1: quiet nets, scan lasts exactly N_SIG cycles
    resetDut();
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_busy_start", 32'(busy), 1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      step(1);
    end
    checkOutput("t1_busy_cycles", 32'(cnt), 16);
    checkOutput("t1_no_events", 32'(evt_valid), 0);

    // 2: nets 0 and 2 rise, events arrive in index order
    applyStimulus(16'h0005, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_valid_T1", 32'(evt_valid), 0);
    step(1);
    checkOutput("t2_valid_T2", 32'(evt_valid), 1);
    checkOutput("t2_idx0", 32'(evt_idx), 0);
    checkOutput("t2_val0", 32'(evt_val), 1);
    step(1);
    checkOutput("t2_popped", 32'(evt_valid), 0);
    step(1);
    checkOutput("t2_idx2", 32'(evt_idx), 2);
    checkOutput("t2_val2", 32'(evt_val), 1);
    waitIdle();
    step(2);

    // 3: overflow with consumer stalled, dropped changes re-reported next tick
    resetDut();
    applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t3_overflow", 32'(ovf), 1);
    checkOutput("t3_head_idx", 32'(evt_idx), 0);
    got.delete();
    ready = 1'b1;
    collectUntilQuiet();
    checkOutput("t3_first_count", 32'(got.size()), 8);
    foreach (got[i]) checkOutput("t3_first_idx", 32'(got[i]), 32'(i));
    applyStimulus(16'hFFFF, 1'b0, 1'b1, 1'b1);
    checkOutput("t3_ovf_cleared", 32'(ovf), 0);
    applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b0);
    got.delete();
    collectUntilQuiet();
    checkOutput("t3_second_count", 32'(got.size()), 8);
    foreach (got[i]) checkOutput("t3_second_idx", 32'(got[i]), 32'(8 + i));
    checkOutput("t3_no_new_ovf", 32'(ovf), 0);

    // 4: tick during a scan is flagged and ignored
    resetDut();
    applyStimulus(16'h0003, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0003, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0003, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0003, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_tick_miss", 32'(miss), 1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      step(1);
    end
    checkOutput("t4_remaining_busy", 32'(cnt), 13);
    step(3);
    checkOutput("t4_no_rescan", 32'(busy), 0);
    got.delete();
    ready = 1'b1;
    collectUntilQuiet();
    checkOutput("t4_event_count", 32'(got.size()), 2);
    applyStimulus(16'h0003, 1'b0, 1'b1, 1'b1);
    checkOutput("t4_miss_cleared", 32'(miss), 0);
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0);
    step(1);
    checkOutput("t4_fall_valid", 32'(evt_valid), 1);
    checkOutput("t4_fall_idx", 32'(evt_idx), 0);
    checkOutput("t4_fall_val", 32'(evt_val), 0);
`ifdef RSIO_TIMESTAMP_EN
    checkOutput("t4_fall_ts", 32'(evt_ts), 1);
`endif
    got.delete();
    collectUntilQuiet();
    checkOutput("t4_fall_count", 32'(got.size()), 2);

    // 5: head holds while stalled, then one pop per cycle
    resetDut();
    applyStimulus(16'h0081, 1'b1, 1'b0, 1'b0);
    waitIdle();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5_hold_valid", 32'(evt_valid), 1);
      checkOutput("t5_hold_idx", 32'(evt_idx), 0);
      checkOutput("t5_hold_val", 32'(evt_val), 1);
      step(1);
    end
    ready = 1'b1;
    step(1);
    checkOutput("t5_second_idx", 32'(evt_idx), 7);
    checkOutput("t5_second_valid", 32'(evt_valid), 1);
    step(1);
    checkOutput("t5_drained", 32'(evt_valid), 0);

    // 6: reset in the middle of a scan
    resetDut();
    applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b0);
    step(5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_valid", 32'(evt_valid), 0);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_overflow", 32'(ovf), 0);
    checkOutput("t6_tick_miss", 32'(miss), 0);
    checkOutput("t6_idx", 32'(evt_idx), 0);
    checkOutput("t6_val", 32'(evt_val), 0);
    step(1);
    rst = 1'b0;
    applyStimulus(16'h0003, 1'b1, 1'b1, 1'b0);
    got.delete();
    collectUntilQuiet();
    checkOutput("t6_event_count", 32'(got.size()), 2);
    foreach (got[i]) checkOutput("t6_event_idx", 32'(got[i]), 32'(i));

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
